area_classifier_n: RTL and testbench

//  Parametrised point classifier. Starts conversion on two ADCs (X, Y) with a
//  soc/eoc handshake, classifies the signed point (x,y) against a square and a

---
 rtl/area_classifier_n.sv | 99 +++++++++
 tb/tb_area_classifier_n.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/area_classifier_n.sv
// rtl/area_classifier_n.sv - dual-ADC point classifier (square/diamond) with dav_/rfd delivery and saturating hit count
module area_classifier_n #(
  parameter int N    = 8,
  parameter int SIDE = 48,
  parameter int RAD  = 64,
  parameter int CW   = 8
) (
  input  logic          clock,
  input  logic          reset_,
  output logic          soc_x,
  input  logic          eoc_x,
  input  logic [N-1:0]  x,
  output logic          soc_y,
  input  logic          eoc_y,
  input  logic [N-1:0]  y,
  input  logic [1:0]    mode,
  output logic          dav_,
  input  logic          rfd,
  output logic          z,
  output logic [CW-1:0] hits
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  localparam logic [N-1:0] SIDE_U = N'(SIDE);
  localparam logic [N:0]   RAD_U  = (N+1)'(RAD);

  state_t        r_state;
  state_t        w_next;
  logic          r_soc;
  logic          r_dav_n;
  logic          r_z;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_hits;

  logic [N-1:0]  w_ax;
  logic [N-1:0]  w_ay;
  logic [N:0]    w_sum;
  logic          w_in_sq;
  logic          w_in_dm;
  logic          w_f;

  // Unsigned magnitude: the most negative code maps to 2^(N-1) exactly.
  assign w_ax    = x[N-1] ? (-x) : x;
  assign w_ay    = y[N-1] ? (-y) : y;
  assign w_sum   = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_in_sq = (w_ax <= SIDE_U) && (w_ay <= SIDE_U);
  assign w_in_dm = (w_sum <= RAD_U);

  always_comb begin
    w_f = 1'b0;
    case (r_mode)
      2'b00:   w_f = w_in_sq;
      2'b01:   w_f = w_in_dm;
      2'b10:   w_f = w_in_sq ^ w_in_dm;
      default: w_f = w_in_sq & w_in_dm;
    endcase
  end

  // S0 waits for r_soc so the first cycle after reset still raises soc.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S0: if (r_soc && !eoc_x && !eoc_y) w_next = S1;
      S1: if (eoc_x && eoc_y)            w_next = S2;
      S2: if (!rfd)                      w_next = S3;
      S3: if (rfd)                       w_next = S0;
      default:                           w_next = S0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= S0;
      r_soc   <= 1'b0;
      r_dav_n <= 1'b1;
      r_z     <= 1'b0;
      r_mode  <= 2'b00;
      r_hits  <= '0;
    end else begin
      r_state <= w_next;
      r_soc   <= (w_next == S0);
      r_dav_n <= (w_next != S2);
      if (r_state == S0 && w_next == S1)
        r_mode <= mode;
      if (r_state == S1 && w_next == S2)
        r_z <= w_f;
      if (r_state == S2 && w_next == S3 && r_z && (r_hits != {CW{1'b1}}))
        r_hits <= r_hits + 1'b1;
    end
  end

  assign soc_x = r_soc;
  assign soc_y = r_soc;
  assign dav_  = r_dav_n;
  assign z     = r_z;
  assign hits  = r_hits;

endmodule

// File: tb/tb_area_classifier_n.sv
// tb/tb_area_classifier_n.sv - scoreboard bench for area_classifier_n (CW=8 and CW=2 instances)
module tb_area_classifier_n;

  logic       clock;
  logic       reset_;
  logic       eoc_x, eoc_y, rfd;
  logic [7:0] x, y;
  logic [1:0] mode;

  logic       soc_x, soc_y, dav_, z;
  logic [7:0] hits;
  logic       soc_x2, soc_y2, dav2_, z2;
  logic [1:0] hits2;

  int tests_run;
  int tests_failed;
  int mh;
  int mh2;
  bit exp_q[$];

  area_classifier_n #(.N(8), .SIDE(48), .RAD(64), .CW(8)) dut (
    .clock(clock), .reset_(reset_), .soc_x(soc_x), .eoc_x(eoc_x), .x(x),
    .soc_y(soc_y), .eoc_y(eoc_y), .y(y), .mode(mode), .dav_(dav_), .rfd(rfd),
    .z(z), .hits(hits)
  );

  area_classifier_n #(.N(8), .SIDE(48), .RAD(64), .CW(2)) dut2 (
    .clock(clock), .reset_(reset_), .soc_x(soc_x2), .eoc_x(eoc_x), .x(x),
    .soc_y(soc_y2), .eoc_y(eoc_y), .y(y), .mode(mode), .dav_(dav2_), .rfd(rfd),
    .z(z2), .hits(hits2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit model_z(input logic [1:0] m, input int xv, input int yv);
    int  ax, ay;
    bit  sq, dm;
    ax = (xv < 0) ? -xv : xv;
    ay = (yv < 0) ? -yv : yv;
    sq = (ax <= 48) && (ay <= 48);
    dm = (ax + ay) <= 64;
    case (m)
      2'b00:   return sq;
      2'b01:   return dm;
      2'b10:   return sq ^ dm;
      default: return sq & dm;
    endcase
  endfunction

  task automatic wait_soc(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (soc_x === 1'b1) begin
        ok = 1;
        break;
      end
    end
    tests_run++;
    if (!ok || soc_y !== soc_x || soc_x2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_soc: got soc_x=%b soc_y=%b soc_x2=%b expected 1 1 1", name, soc_x, soc_y, soc_x2);
    end
  endtask

  task automatic finish_point(input bit ez, input string name);
    bit e;
    @(negedge clock);
    tests_run++;
    if (dav_ !== 1'b0 || dav2_ !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_dav: got %b/%b expected 0", name, dav_, dav2_);
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_z: got %b expected <empty scoreboard>", name, z);
    end else begin
      e = exp_q.pop_front();
      if (z !== e || z2 !== e) begin
        tests_failed++;
        $display("FAIL %s_z: got %b/%b expected %b", name, z, z2, e);
      end
    end
    eoc_x = 1'b0;
    eoc_y = 1'b0;
    rfd   = 1'b0;
    @(negedge clock);
    if (ez) begin
      if (mh < 255) mh++;
      if (mh2 < 3) mh2++;
    end
    tests_run++;
    if (dav_ !== 1'b1 || hits !== 8'(mh) || hits2 !== 2'(mh2)) begin
      tests_failed++;
      $display("FAIL %s_hits: got dav_=%b hits=%0d hits2=%0d expected dav_=1 hits=%0d hits2=%0d",
               name, dav_, hits, hits2, mh, mh2);
    end
    rfd = 1'b1;
  endtask

  task automatic do_point(input int xv, input int yv, input logic [1:0] m, input bit ez, input string name);
    wait_soc(name);
    mode = m;
    @(negedge clock);
    tests_run++;
    if (soc_x !== 1'b0 || dav_ !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_s1: got soc_x=%b dav_=%b expected 0 1", name, soc_x, dav_);
    end
    x = 8'(xv);
    y = 8'(yv);
    eoc_x = 1'b1;
    eoc_y = 1'b1;
    exp_q.push_back(ez);
    finish_point(ez, name);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_ = 1'b0;
    eoc_x = 1'b0;
    eoc_y = 1'b0;
    rfd = 1'b1;
    exp_q.delete();
    mh = 0;
    mh2 = 0;
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    eoc_x = 1'b0; eoc_y = 1'b0; rfd = 1'b1;
    x = '0; y = '0; mode = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (soc_x !== 1'b0 || soc_y !== 1'b0 || dav_ !== 1'b1 || z !== 1'b0 || hits !== 8'd0 || hits2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got soc=%b%b dav_=%b z=%b hits=%0d hits2=%0d expected 00 1 0 0 0",
               soc_x, soc_y, dav_, z, hits, hits2);
    end
    reset_ = 1'b1;
    @(posedge clock);
    #1;
    tests_run++;
    if (soc_x !== 1'b1 || soc_y !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_soc: got %b%b expected 11", soc_x, soc_y);
    end
  endtask

  task automatic test_square();
    do_point(48, -48, 2'b00, 1'b1, "sq_corner");
    do_point(49, 0, 2'b00, 1'b0, "sq_out");
    do_point(-128, 0, 2'b00, 1'b0, "sq_minint");
  endtask

  task automatic test_diamond();
    do_point(-32, -32, 2'b01, 1'b1, "dm_edge");
    do_point(33, 32, 2'b01, 1'b0, "dm_out");
    do_point(0, -64, 2'b01, 1'b1, "dm_tip");
  endtask

  task automatic test_xor_and();
    do_point(40, 40, 2'b10, 1'b1, "xor_sq");
    do_point(0, 60, 2'b10, 1'b1, "xor_dm");
    do_point(0, 0, 2'b10, 1'b0, "xor_both");
    do_point(0, 0, 2'b11, 1'b1, "and_both");
    do_point(40, 40, 2'b11, 1'b0, "and_sq");
  endtask

  task automatic test_skew();
    wait_soc("skew");
    mode = 2'b00;
    @(negedge clock);
    eoc_x = 1'b1;
    x = 8'd10;
    y = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (dav_ !== 1'b1 || soc_x !== 1'b0) begin
        tests_failed++;
        $display("FAIL skew_wait%0d: got dav_=%b soc_x=%b expected 1 0", i, dav_, soc_x);
      end
    end
    x = 8'd60;
    eoc_y = 1'b1;
    exp_q.push_back(model_z(2'b00, 60, 5));
    finish_point(model_z(2'b00, 60, 5), "skew");
  endtask

  task automatic test_mode_hold();
    wait_soc("mode_hold");
    mode = 2'b00;
    @(negedge clock);
    mode = 2'b01;
    x = 8'd0;
    y = 8'd60;
    eoc_x = 1'b1;
    eoc_y = 1'b1;
    exp_q.push_back(1'b0);
    finish_point(1'b0, "mode_hold");
  endtask

  task automatic test_back_to_back();
    int xv, yv;
    logic [1:0] m;
    for (int i = 0; i < 8; i++) begin
      xv = int'($urandom_range(0, 255)) - 128;
      yv = int'($urandom_range(0, 255)) - 128;
      m  = 2'($urandom_range(0, 3));
      do_point(xv, yv, m, model_z(m, xv, yv), "b2b");
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int i = 0; i < 5; i++)
      do_point(i, -i, 2'b00, 1'b1, "sat_in");
    do_point(100, 0, 2'b00, 1'b0, "sat_out");
    tests_run++;
    if (hits2 !== 2'd3 || hits !== 8'd5) begin
      tests_failed++;
      $display("FAIL sat_final: got hits2=%0d hits=%0d expected 3 5", hits2, hits);
    end
  endtask

  task automatic test_reset_mid();
    wait_soc("rst_mid");
    mode = 2'b00;
    @(negedge clock);
    x = 8'd1;
    y = 8'd1;
    eoc_x = 1'b1;
    eoc_y = 1'b1;
    @(negedge clock);
    tests_run++;
    if (dav_ !== 1'b0 || z !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_s2: got dav_=%b z=%b expected 0 1", dav_, z);
    end
    #2;
    reset_ = 1'b0;
    #1;
    tests_run++;
    if (dav_ !== 1'b1 || soc_x !== 1'b0 || hits !== 8'd0 || hits2 !== 2'd0 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got dav_=%b soc=%b hits=%0d hits2=%0d z=%b expected 1 0 0 0 0",
               dav_, soc_x, hits, hits2, z);
    end
    exp_q.delete();
    mh = 0;
    mh2 = 0;
    eoc_x = 1'b0;
    eoc_y = 1'b0;
    rfd = 1'b1;
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock);
    #1;
    tests_run++;
    if (soc_x !== 1'b1 || dav_ !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_restart: got soc=%b dav_=%b expected 1 1", soc_x, dav_);
    end
    do_point(-20, 30, 2'b01, 1'b1, "rst_mid_after");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    mh = 0;
    mh2 = 0;
    test_reset();
    test_square();
    test_diamond();
    test_xor_and();
    test_skew();
    test_mode_hold();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
